call_stack_sequencer: RTL

Multi-cycle sequencer that performs the stack micro-operations of CALL, CALZ, RET and RETS for the 4-bit core. It owns the single nibble-wide data-RAM port for the duration of an operation. It writes or reads the three return-address nibbles (PCP, PCSH, PCSL) at SP-relative addresses, then commits the new PC and SP to the register file in one cycle. It sits between the instruction decoder and the RAM/regs blocks.

---
 rtl/call_stack_sequencer_if.sv | 52 +++++
 rtl/call_stack_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/call_stack_sequencer_if.sv
// Bus bundle for call_stack_sequencer: decoder request/latch inputs,
// the nibble-wide data-RAM port and the PC/SP commit outputs.
//   master : decoder/RAM/regs side (drives requests and ram_rdata)
//   slave  : the sequencer itself
// Optional macro CALL_STACK_RETD_EN adds start_retd, retd_data, x_in, x_out and x_we.
interface call_stack_sequencer_if #(
  parameter int unsigned RAM_ADDR_WIDTH = 12
);
  logic                      start_call;
  logic                      is_calz;
  logic                      start_ret;
  logic                      ret_skip;
  logic [7:0]                target;
  logic [4:0]                np;
  logic [12:0]               pc;
  logic [7:0]                sp_in;
  logic [3:0]                ram_rdata;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic [3:0]                ram_wdata;
  logic                      ram_we;
  logic [12:0]               pc_out;
  logic                      pc_we;
  logic [7:0]                sp_out;
  logic                      sp_we;
  logic                      busy;
  logic                      done;
`ifdef CALL_STACK_RETD_EN
  logic                      start_retd;
  logic [7:0]                retd_data;
  logic [11:0]               x_in;
  logic [11:0]               x_out;
  logic                      x_we;
`endif

  modport master (
    output start_call, is_calz, start_ret, ret_skip, target, np, pc, sp_in, ram_rdata,
    input  ram_addr, ram_wdata, ram_we, pc_out, pc_we, sp_out, sp_we, busy, done
`ifdef CALL_STACK_RETD_EN
    , output start_retd, retd_data, x_in
    , input  x_out, x_we
`endif
  );

  modport slave (
    input  start_call, is_calz, start_ret, ret_skip, target, np, pc, sp_in, ram_rdata,
    output ram_addr, ram_wdata, ram_we, pc_out, pc_we, sp_out, sp_we, busy, done
`ifdef CALL_STACK_RETD_EN
    , input  start_retd, retd_data, x_in
    , output x_out, x_we
`endif
  );
endinterface

// File: rtl/call_stack_sequencer.sv
// Multi-cycle CALL/CALZ/RET/RETS stack sequencer for the 4-bit core. Owns the
// data-RAM port while busy, pushes/pops the three return-address nibbles at
// SP-relative addresses, then commits new PC and SP in a single cycle.
// Ports:
//   i_clk      core clock
//   i_reset_n  synchronous active-low reset
//   i_clk_en   CPU tick; state advances only when high
//   io_bus     call_stack_sequencer_if.slave (requests, RAM port, PC/SP commit)
// Optional macro CALL_STACK_RETD_EN adds RETD (pop, then write retd_data to M(x), M(x+1)).
module call_stack_sequencer #(
  parameter int unsigned RAM_ADDR_WIDTH = 12,
  parameter logic [3:0]  STACK_PAGE     = 4'h0
) (
  input logic                   i_clk,
  input logic                   i_reset_n,
  input logic                   i_clk_en,
  call_stack_sequencer_if.slave io_bus
);

  typedef enum logic [3:0] {
    StIdle, StPushP, StPushH, StPushL, StPopL, StPopH, StPopP, StCommit
`ifdef CALL_STACK_RETD_EN
    , StWrXl, StWrXh
`endif
  } state_e;

  state_e      r_state, w_state_d;
  logic [12:0] r_pc;
  logic [3:0]  r_np;
  logic [7:0]  r_target;
  logic        r_calz;
  logic        r_skip;
  logic        r_is_ret;
  logic [7:0]  r_sp;
  logic [11:0] r_pop;
  logic        w_unused_np;

  logic        w_sel_call, w_sel_retd, w_sel_ret, w_accept;
  logic [11:0] w_ret;
  logic [11:0] w_addr;
  logic [3:0]  w_wdata;
  logic        w_we;
  logic [12:0] w_pc_out;
  logic [7:0]  w_sp_out;
  logic        w_commit;

`ifdef CALL_STACK_RETD_EN
  logic        r_retd;
  logic [7:0]  r_retd_data;
  logic [11:0] r_x;
  logic [11:0] w_x_out;
  logic        w_x_we;
  assign w_sel_retd = !io_bus.start_call && io_bus.start_retd;
`else
  assign w_sel_retd = 1'b0;
`endif

  assign w_unused_np = io_bus.np[4];
  // Priority: call > retd > ret; losing requests are dropped.
  assign w_sel_call  = io_bus.start_call;
  assign w_sel_ret   = !io_bus.start_call && !w_sel_retd && io_bus.start_ret;
  assign w_accept    = w_sel_call || w_sel_retd || w_sel_ret;
  // Return address wraps within 12 bits; the bank bit is never touched.
  assign w_ret       = r_pc[11:0] + 12'h001;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
    end else if (i_clk_en) begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_sel_call) begin
          w_state_d = StPushP;
        end else if (w_accept) begin
          w_state_d = StPopL;
        end
      end
      StPushP:  w_state_d = StPushH;
      StPushH:  w_state_d = StPushL;
      StPushL:  w_state_d = StCommit;
      StPopL:   w_state_d = StPopH;
      StPopH:   w_state_d = StPopP;
`ifdef CALL_STACK_RETD_EN
      StPopP:   w_state_d = r_retd ? StWrXl : StCommit;
      StWrXl:   w_state_d = StWrXh;
      StWrXh:   w_state_d = StCommit;
`else
      StPopP:   w_state_d = StCommit;
`endif
      StCommit: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Operand latches and popped return address
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_pc        <= '0;
      r_np        <= '0;
      r_target    <= '0;
      r_calz      <= 1'b0;
      r_skip      <= 1'b0;
      r_is_ret    <= 1'b0;
      r_sp        <= '0;
      r_pop       <= '0;
`ifdef CALL_STACK_RETD_EN
      r_retd      <= 1'b0;
      r_retd_data <= '0;
      r_x         <= '0;
`endif
    end else if (i_clk_en) begin
      if (r_state == StIdle && w_accept) begin
        r_pc        <= io_bus.pc;
        r_np        <= io_bus.np[3:0];
        r_target    <= io_bus.target;
        r_calz      <= io_bus.is_calz;
        r_skip      <= w_sel_ret && io_bus.ret_skip;
        r_is_ret    <= !w_sel_call;
        r_sp        <= io_bus.sp_in;
`ifdef CALL_STACK_RETD_EN
        r_retd      <= w_sel_retd;
        r_retd_data <= io_bus.retd_data;
        r_x         <= io_bus.x_in;
`endif
      end
      case (r_state)
        StPopL:  r_pop[3:0]  <= io_bus.ram_rdata;
        StPopH:  r_pop[7:4]  <= io_bus.ram_rdata;
        StPopP:  r_pop[11:8] <= io_bus.ram_rdata;
        default: ;
      endcase
    end
  end

  // Outputs; everything is zero outside the states that drive it.
  always_comb begin
    w_addr   = 12'h000;
    w_wdata  = 4'h0;
    w_we     = 1'b0;
    w_pc_out = '0;
    w_sp_out = '0;
    w_commit = 1'b0;
`ifdef CALL_STACK_RETD_EN
    w_x_out  = '0;
    w_x_we   = 1'b0;
`endif
    case (r_state)
      StPushP: begin
        w_addr  = {STACK_PAGE, r_sp - 8'd1};
        w_wdata = w_ret[11:8];
        w_we    = 1'b1;
      end
      StPushH: begin
        w_addr  = {STACK_PAGE, r_sp - 8'd2};
        w_wdata = w_ret[7:4];
        w_we    = 1'b1;
      end
      StPushL: begin
        w_addr  = {STACK_PAGE, r_sp - 8'd3};
        w_wdata = w_ret[3:0];
        w_we    = 1'b1;
      end
      StPopL: w_addr = {STACK_PAGE, r_sp};
      StPopH: w_addr = {STACK_PAGE, r_sp + 8'd1};
      StPopP: w_addr = {STACK_PAGE, r_sp + 8'd2};
`ifdef CALL_STACK_RETD_EN
      StWrXl: begin
        w_addr  = r_x;
        w_wdata = r_retd_data[3:0];
        w_we    = 1'b1;
      end
      StWrXh: begin
        w_addr  = r_x + 12'd1;
        w_wdata = r_retd_data[7:4];
        w_we    = 1'b1;
      end
`endif
      StCommit: begin
        w_commit = 1'b1;
        if (r_is_ret) begin
          w_pc_out = {r_pc[12], r_pop + {11'd0, r_skip}};
          w_sp_out = r_sp + 8'd3;
        end else begin
          w_pc_out = {r_pc[12], r_calz ? 4'h0 : r_np, r_target};
          w_sp_out = r_sp - 8'd3;
        end
`ifdef CALL_STACK_RETD_EN
        if (r_retd) begin
          w_x_out = r_x + 12'd2;
          w_x_we  = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  assign io_bus.ram_addr  = RAM_ADDR_WIDTH'(w_addr);
  assign io_bus.ram_wdata = w_wdata;
  assign io_bus.ram_we    = w_we;
  assign io_bus.pc_out    = w_pc_out;
  assign io_bus.pc_we     = w_commit;
  assign io_bus.sp_out    = w_sp_out;
  assign io_bus.sp_we     = w_commit;
  assign io_bus.done      = w_commit;
  assign io_bus.busy      = (r_state != StIdle);
`ifdef CALL_STACK_RETD_EN
  assign io_bus.x_out     = w_x_out;
  assign io_bus.x_we      = w_x_we;
`endif

endmodule
